// File: rtl/bp_fe_instr_realigner.sv
// Splits the word-aligned 32-bit fetch stream into RV64GC instructions on 16-bit
// boundaries, stitching 32-bit instructions that straddle two fetch words.
module bp_fe_instr_realigner #(
  parameter int unsigned vaddr_width_p = 39
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     fetch_v_i,
  input  logic [vaddr_width_p-1:0] fetch_pc_i,
  input  logic [31:0]              fetch_data_i,
  output logic                     fetch_ready_o,
  output logic                     instr_v_o,
  output logic [31:0]              instr_o,
  output logic [vaddr_width_p-1:0] instr_pc_o,
  output logic                     instr_compressed_o,
  input  logic                     instr_yumi_i
);

  localparam int unsigned VW = vaddr_width_p;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_STITCH,
    SEL_RVC,
    SEL_FULL,
    SEL_SPILL
  } sel_e;

  logic [31:0]   word_r;
  logic [VW-1:0] word_pc_r;
  logic          off_r;
  logic          word_v_r;
  logic [15:0]   hold_r;
  logic [VW-1:0] hold_pc_r;
  logic          hold_v_r;

  sel_e          sel;
  logic [15:0]   parcel;
  logic [VW-1:0] parcel_pc;
  logic          active;
  logic          take;
  logic          retire;
  logic          accept;
  logic          unused_pc_lsb;

  assign unused_pc_lsb = fetch_pc_i[0];

  // Decode what the buffered state offers this cycle
  always_comb begin
    sel       = SEL_NONE;
    parcel    = off_r ? word_r[31:16] : word_r[15:0];
    parcel_pc = {word_pc_r[VW-1:2], off_r, 1'b0};
    if (word_v_r) begin
      if (hold_v_r)                 sel = SEL_STITCH;
      else if (parcel[1:0] != 2'b11) sel = SEL_RVC;
      else if (!off_r)              sel = SEL_FULL;
      else                          sel = SEL_SPILL;
    end
  end

  // Output mux and handshake; reset and flush mask everything
  always_comb begin
    active             = ~reset_i & ~flush_i;
    instr_v_o          = 1'b0;
    instr_o            = '0;
    instr_pc_o         = '0;
    instr_compressed_o = 1'b0;
    if (active) begin
      case (sel)
        SEL_STITCH: begin
          instr_v_o  = 1'b1;
          instr_o    = {word_r[15:0], hold_r};
          instr_pc_o = hold_pc_r;
        end
        SEL_RVC: begin
          instr_v_o          = 1'b1;
          instr_o            = {16'b0, parcel};
          instr_pc_o         = parcel_pc;
          instr_compressed_o = 1'b1;
        end
        SEL_FULL: begin
          instr_v_o  = 1'b1;
          instr_o    = word_r;
          instr_pc_o = word_pc_r;
        end
        default: ;
      endcase
    end
    take          = instr_v_o & instr_yumi_i;
    retire        = active & ((sel == SEL_SPILL)
                    | (take & (((sel == SEL_RVC) & off_r) | (sel == SEL_FULL))));
    fetch_ready_o = active & (~word_v_r | retire);
    accept        = fetch_v_i & fetch_ready_o;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      word_r    <= '0;
      word_pc_r <= '0;
      off_r     <= 1'b0;
      word_v_r  <= 1'b0;
      hold_r    <= '0;
      hold_pc_r <= '0;
      hold_v_r  <= 1'b0;
    end else if (flush_i) begin
      word_v_r <= 1'b0;
      hold_v_r <= 1'b0;
    end else begin
      if (sel == SEL_SPILL) begin
        hold_r    <= parcel;
        hold_pc_r <= {word_pc_r[VW-1:2], 2'b10};
        hold_v_r  <= 1'b1;
      end
      if (take && (sel == SEL_STITCH)) begin
        hold_v_r <= 1'b0;
        off_r    <= 1'b1;
      end
      if (take && (sel == SEL_RVC) && !off_r) off_r <= 1'b1;
      if (retire) word_v_r <= 1'b0;
      // A half-aligned start means the stream broke, so any held lower half is stale
      if (accept) begin
        word_r    <= fetch_data_i;
        word_pc_r <= {fetch_pc_i[VW-1:2], 2'b00};
        off_r     <= fetch_pc_i[1];
        word_v_r  <= 1'b1;
        if (fetch_pc_i[1]) hold_v_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bp_fe_instr_realigner.sv
// Directed and randomized checks of the instruction realigner against a
// parcel-queue reference model.
module tb_bp_fe_instr_realigner;

  localparam int unsigned VW = 39;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          flush_i;
  logic          fetch_v_i;
  logic [VW-1:0] fetch_pc_i;
  logic [31:0]   fetch_data_i;
  logic          fetch_ready_o;
  logic          instr_v_o;
  logic [31:0]   instr_o;
  logic [VW-1:0] instr_pc_o;
  logic          instr_compressed_o;
  logic          instr_yumi_i;

  int n_checks = 0;
  int n_fail   = 0;
  int n_emit   = 0;

  logic [15:0]   pq_data[$];
  logic [VW-1:0] pq_pc[$];

  bp_fe_instr_realigner #(.vaddr_width_p(VW)) dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .flush_i            (flush_i),
    .fetch_v_i          (fetch_v_i),
    .fetch_pc_i         (fetch_pc_i),
    .fetch_data_i       (fetch_data_i),
    .fetch_ready_o      (fetch_ready_o),
    .instr_v_o          (instr_v_o),
    .instr_o            (instr_o),
    .instr_pc_o         (instr_pc_o),
    .instr_compressed_o (instr_compressed_o),
    .instr_yumi_i       (instr_yumi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
    instr_yumi_i = 1'b0;
  endtask

  task automatic offer(input logic v, input logic [VW-1:0] pc, input logic [31:0] d);
    fetch_v_i    = v;
    fetch_pc_i   = pc;
    fetch_data_i = d;
  endtask

  task automatic expect_instr(input string tag, input logic v, input logic [31:0] ins,
                              input logic [VW-1:0] pc, input logic c, input logic take);
    @(negedge clk_i);
    chk({tag, "_v"}, 64'(instr_v_o), 64'(v));
    if (v) begin
      chk({tag, "_instr"}, 64'(instr_o), 64'(ins));
      chk({tag, "_pc"}, 64'(instr_pc_o), 64'(pc));
      chk({tag, "_c"}, 64'(instr_compressed_o), 64'(c));
    end
    instr_yumi_i = take & instr_v_o;
    #1;
  endtask

  function automatic logic [15:0] rand_parcel();
    logic [15:0] p;
    p = 16'($urandom);
    if ($urandom_range(0, 1) == 1) p[1:0] = 2'b11;
    else if (p[1:0] == 2'b11) p[1:0] = 2'b01;
    return p;
  endfunction

  // Compare the DUT's offer against the head of the parcel queue, maybe consume it
  task automatic model_observe(input int take_pct);
    int          n;
    logic [15:0] p0;
    logic [31:0] exp_i;
    logic        exp_c;
    n = 0;
    if (instr_v_o) begin
      if (pq_data.size() == 0) begin
        chk("rnd_spurious_v", 64'(instr_v_o), 64'(0));
      end else begin
        p0 = pq_data[0];
        if (p0[1:0] != 2'b11) begin
          exp_i = {16'b0, p0};
          exp_c = 1'b1;
          n     = 1;
        end else if (pq_data.size() >= 2) begin
          exp_i = {pq_data[1], p0};
          exp_c = 1'b0;
          n     = 2;
        end else begin
          chk("rnd_incomplete_v", 64'(instr_v_o), 64'(0));
        end
        if (n > 0) begin
          chk("rnd_instr", 64'(instr_o), 64'(exp_i));
          chk("rnd_pc", 64'(instr_pc_o), 64'(pq_pc[0]));
          chk("rnd_c", 64'(instr_compressed_o), 64'(exp_c));
          if (int'($urandom_range(0, 99)) < take_pct) begin
            instr_yumi_i = 1'b1;
            n_emit++;
            for (int k = 0; k < n; k++) begin
              void'(pq_data.pop_front());
              void'(pq_pc.pop_front());
            end
          end
        end
      end
    end
  endtask

  logic          fl;
  logic          have_word;
  logic          redirect;
  logic [VW-1:0] w_pc;
  logic [VW-1:0] next_pc;
  logic [31:0]   w_data;
  int            lone;

  initial begin
    reset_i = 1'b1;
    flush_i = 1'b0;
    instr_yumi_i = 1'b0;
    offer(1'b0, '0, '0);
    adv();
    adv();
    @(negedge clk_i);
    chk("reset_v", 64'(instr_v_o), 64'(0));
    chk("reset_ready", 64'(fetch_ready_o), 64'(0));
    chk("reset_instr", 64'(instr_o), 64'(0));
    chk("reset_pc", 64'(instr_pc_o), 64'(0));
    adv();
    reset_i = 1'b0;

    // Two compressed parcels in one word
    offer(1'b1, VW'(32'h1000), 32'h45054501);
    expect_instr("t1_idle", 1'b0, '0, '0, 1'b0, 1'b1);
    chk("t1_ready_first", 64'(fetch_ready_o), 64'(1));
    adv();
    offer(1'b0, '0, '0);
    expect_instr("t1_a", 1'b1, 32'h00004501, VW'(32'h1000), 1'b1, 1'b1);
    adv();
    expect_instr("t1_b", 1'b1, 32'h00004505, VW'(32'h1002), 1'b1, 1'b1);
    chk("t1_ready_b", 64'(fetch_ready_o), 64'(1));
    adv();
    expect_instr("t1_done", 1'b0, '0, '0, 1'b0, 1'b0);
    adv();

    // Back-to-back 32-bit words
    offer(1'b1, VW'(32'h2000), 32'h00100093);
    expect_instr("t2_idle", 1'b0, '0, '0, 1'b0, 1'b0);
    chk("t2_ready0", 64'(fetch_ready_o), 64'(1));
    adv();
    offer(1'b1, VW'(32'h2004), 32'h00200113);
    expect_instr("t2_a", 1'b1, 32'h00100093, VW'(32'h2000), 1'b0, 1'b1);
    chk("t2_ready1", 64'(fetch_ready_o), 64'(1));
    adv();
    offer(1'b0, '0, '0);
    expect_instr("t2_b", 1'b1, 32'h00200113, VW'(32'h2004), 1'b0, 1'b1);
    chk("t2_ready2", 64'(fetch_ready_o), 64'(1));
    adv();
    expect_instr("t2_done", 1'b0, '0, '0, 1'b0, 1'b0);
    adv();

    // Straddling 32-bit instruction
    offer(1'b1, VW'(32'h3000), 32'h00934501);
    expect_instr("t3_idle", 1'b0, '0, '0, 1'b0, 1'b0);
    adv();
    offer(1'b1, VW'(32'h3004), 32'h45050010);
    expect_instr("t3_a", 1'b1, 32'h00004501, VW'(32'h3000), 1'b1, 1'b1);
    chk("t3_ready_a", 64'(fetch_ready_o), 64'(0));
    adv();
    expect_instr("t3_spill", 1'b0, '0, '0, 1'b0, 1'b0);
    chk("t3_ready_spill", 64'(fetch_ready_o), 64'(1));
    adv();
    offer(1'b0, '0, '0);
    expect_instr("t3_stitch", 1'b1, 32'h00100093, VW'(32'h3002), 1'b0, 1'b1);
    adv();
    expect_instr("t3_b", 1'b1, 32'h00004505, VW'(32'h3006), 1'b1, 1'b1);
    adv();
    expect_instr("t3_done", 1'b0, '0, '0, 1'b0, 1'b0);
    adv();

    // Half-aligned redirect target
    offer(1'b1, VW'(32'h4002), 32'h4505ffff);
    expect_instr("t4_idle", 1'b0, '0, '0, 1'b0, 1'b0);
    adv();
    offer(1'b0, '0, '0);
    expect_instr("t4_a", 1'b1, 32'h00004505, VW'(32'h4002), 1'b1, 1'b1);
    chk("t4_ready_a", 64'(fetch_ready_o), 64'(1));
    adv();
    expect_instr("t4_done", 1'b0, '0, '0, 1'b0, 1'b0);
    chk("t4_ready_done", 64'(fetch_ready_o), 64'(1));
    adv();

    // Flush while a lower half is held
    offer(1'b1, VW'(32'h3000), 32'h00934501);
    expect_instr("t5_idle", 1'b0, '0, '0, 1'b0, 1'b0);
    adv();
    offer(1'b0, '0, '0);
    expect_instr("t5_a", 1'b1, 32'h00004501, VW'(32'h3000), 1'b1, 1'b1);
    adv();
    expect_instr("t5_spill", 1'b0, '0, '0, 1'b0, 1'b0);
    adv();
    flush_i = 1'b1;
    expect_instr("t5_flush", 1'b0, '0, '0, 1'b0, 1'b0);
    chk("t5_ready_flush", 64'(fetch_ready_o), 64'(0));
    adv();
    flush_i = 1'b0;
    offer(1'b1, VW'(32'h5000), 32'h00100093);
    expect_instr("t5_idle2", 1'b0, '0, '0, 1'b0, 1'b0);
    chk("t5_ready_new", 64'(fetch_ready_o), 64'(1));
    adv();
    offer(1'b0, '0, '0);
    expect_instr("t5_new", 1'b1, 32'h00100093, VW'(32'h5000), 1'b0, 1'b1);
    adv();
    expect_instr("t5_done", 1'b0, '0, '0, 1'b0, 1'b0);
    adv();

    // Back-pressure, then reset mid-stall
    offer(1'b1, VW'(32'h6000), 32'h00300193);
    expect_instr("t6_idle", 1'b0, '0, '0, 1'b0, 1'b0);
    adv();
    offer(1'b1, VW'(32'h6004), 32'h00400213);
    for (int i = 0; i < 3; i++) begin
      expect_instr("t6_stall", 1'b1, 32'h00300193, VW'(32'h6000), 1'b0, 1'b0);
      chk("t6_ready_stall", 64'(fetch_ready_o), 64'(0));
      adv();
    end
    reset_i = 1'b1;
    expect_instr("t6_reset", 1'b0, '0, '0, 1'b0, 1'b0);
    chk("t6_ready_reset", 64'(fetch_ready_o), 64'(0));
    adv();
    reset_i = 1'b0;
    offer(1'b0, '0, '0);
    expect_instr("t6_after", 1'b0, '0, '0, 1'b0, 1'b0);
    chk("t6_ready_after", 64'(fetch_ready_o), 64'(1));
    adv();

    // Randomized stream with random back-pressure and flushes
    have_word = 1'b0;
    redirect  = 1'b1;
    next_pc   = '0;
    w_pc      = '0;
    w_data    = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      fl = ($urandom_range(0, 39) == 0);
      if (fl) begin
        flush_i   = 1'b1;
        fetch_v_i = 1'b0;
        have_word = 1'b0;
        redirect  = 1'b1;
      end else begin
        flush_i = 1'b0;
        if (!have_word && ($urandom_range(0, 9) < 7)) begin
          if (redirect) begin
            if ($urandom_range(0, 7) == 0) w_pc = ~VW'(0) - VW'($urandom_range(0, 15));
            else w_pc = VW'({$urandom(), $urandom()});
            w_pc[0]  = 1'b0;
            redirect = 1'b0;
          end else begin
            w_pc = next_pc;
          end
          w_data    = {rand_parcel(), rand_parcel()};
          have_word = 1'b1;
        end
        offer(have_word, w_pc, w_data);
      end
      @(negedge clk_i);
      if (fl) begin
        chk("rnd_flush_v", 64'(instr_v_o), 64'(0));
        pq_data.delete();
        pq_pc.delete();
      end else begin
        model_observe(60);
      end
      #1;
      if (fl) begin
        chk("rnd_flush_ready", 64'(fetch_ready_o), 64'(0));
      end else if (fetch_v_i && fetch_ready_o) begin
        if (!w_pc[1]) begin
          pq_data.push_back(w_data[15:0]);
          pq_pc.push_back({w_pc[VW-1:2], 2'b00});
        end
        pq_data.push_back(w_data[31:16]);
        pq_pc.push_back({w_pc[VW-1:2], 2'b10});
        next_pc   = {w_pc[VW-1:2], 2'b00} + VW'(4);
        have_word = 1'b0;
      end
      adv();
    end

    // Drain whatever is buffered
    flush_i = 1'b0;
    offer(1'b0, '0, '0);
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk_i);
      model_observe(100);
      adv();
    end
    lone = (pq_data.size() == 1 && pq_data[0][1:0] == 2'b11) ? 1 : 0;
    chk("drain_left", 64'(pq_data.size() - lone), 64'(0));
    chk("rnd_progress", 64'(n_emit > 300), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_fe_instr_realigner.md
# bp_fe_instr_realigner

Realigns the front end's 32-bit, word-aligned fetch stream into individual RV64GC instructions on 16-bit boundaries. It sits directly upstream of the compressed-instruction expander. For each instruction it emits one entry with its PC and a compressed flag; 16-bit parcels go to the expander, 32-bit instructions bypass it. It stitches 32-bit instructions that straddle two fetch words and handles half-aligned redirect targets.

## Interface
- vaddr_width_p, 39, virtual address width of all PCs
- clk_i  input  1  clock; all state updates on the rising edge
- reset_i  input  1  synchronous, active-high reset
- flush_i  input  1  drop all buffered state (redirect/mispredict)
- fetch_v_i  input  1  fetch word valid
- fetch_pc_i  input  vaddr_width_p  byte PC of first useful parcel; bit[0] always 0; bit[1]=1 means start at upper half
- fetch_data_i  input  32  fetch word; parcel 0 = [15:0], parcel 1 = [31:16]
- fetch_ready_o  output  1  word accepted when fetch_v_i & fetch_ready_o
- instr_v_o  output  1  instruction available
- instr_o  output  32  full instruction, or {16'b0, parcel} when compressed
- instr_pc_o  output  vaddr_width_p  PC of instruction
- instr_compressed_o  output  1  instr_o[15:0] is an RVC parcel (instr_o[1:0] != 2'b11)
- instr_yumi_i  input  1  consumer takes instruction; legal only when instr_v_o=1

## Operation
- State: word_r[31:0], word_pc_r (bits[1:0] stored 0), off_r (parcel index), word_v_r; hold_r[15:0], hold_pc_r, hold_v_r (lower half of a straddling 32-bit instruction).
- Fetch accept: word_r<=fetch_data_i, word_pc_r<={fetch_pc_i[hi:2],2'b00}, off_r<=fetch_pc_i[1], word_v_r<=1. If hold_v_r=1 and fetch_pc_i[1]=1, hold is discarded (discontinuous stream).
- Current parcel p = off_r ? word_r[31:16] : word_r[15:0]. Parcel PC = {word_pc_r[hi:2], off_r, 1'b0}.
- Output selection, priority order, only when word_v_r=1:
  - S1 hold_v_r: instr_o={word_r[15:0],hold_r}, pc=hold_pc_r, compressed=0. On yumi: hold_v_r<=0, off_r<=1.
  - S2 p[1:0]!=2'b11: instr_o={16'b0,p}, pc=parcel PC, compressed=1. On yumi: off_r=0 -> off_r<=1; off_r=1 -> word retires.
  - S3 p[1:0]==2'b11, off_r=0: instr_o=word_r, pc=word_pc_r, compressed=0. On yumi: word retires.
  - S4 p[1:0]==2'b11, off_r=1: instr_v_o=0. Unconditionally hold_r<=p, hold_pc_r<=word_pc_r|2, hold_v_r<=1, and the word retires (spill).
- retire = S4 or (yumi with S2 at off_r=1) or (yumi with S3).
- fetch_ready_o = ~reset_i & ~flush_i & (~word_v_r | retire). The combinational yumi->ready path is intended; it gives one word per cycle for a 32-bit-only stream.
- Accept and retire in the same cycle: new word loads and word_v_r stays 1.
- flush_i: word_v_r<=0, hold_v_r<=0; instr_v_o=0 in that cycle; yumi and fetch ignored. flush_i has priority over everything except reset_i.
- PC arithmetic is modulo 2^vaddr_width_p; hold_pc_r+2 wrap is not checked.

## Timing
- Reset: word_v_r=0, hold_v_r=0, off_r=0; instr_v_o=0, fetch_ready_o=0 during reset, fetch_ready_o=1 the cycle after reset deasserts. instr_o/instr_pc_o are don't-care while instr_v_o=0 but drive 0 from reset.
- Latency: word accepted in cycle N -> first instruction valid in cycle N+1.
- Straddle: spill in cycle N+1, next word accepted N+1 earliest, stitched instruction valid N+2.
- instr_o, instr_pc_o, instr_compressed_o are stable while instr_v_o=1 and instr_yumi_i=0. All outputs are decoded from registers except fetch_ready_o.
- Reset or flush mid-straddle: hold is lost; no stitched instruction is ever emitted from pre-flush data.

## Test plan
- Two RVC: fetch pc 0x1000, data 0x45054501, yumi held 1 -> cycle+1: 0x00004501 @0x1000 c=1; cycle+2: 0x00004505 @0x1002 c=1; fetch_ready_o=1 in cycle+2.
- Back-to-back 32-bit: words 0x00100093 @0x2000, 0x00200113 @0x2004 offered continuously -> one instruction per cycle, c=0, fetch_ready_o never drops.
- Straddle: 0x00934501 @0x3000 then 0x45050010 @0x3004 -> 0x00004501 @0x3000, spill cycle (v=0), 0x00100093 @0x3002 c=0, 0x00004505 @0x3006.
- Half-aligned redirect: fetch pc 0x4002, data 0x4505ffff -> only 0x00004505 @0x4002, then ready.
- Flush with hold_v_r=1 (after the 0x3000 word), then 0x00100093 @0x5000 -> exactly 0x00100093 @0x5000, no stitched output.
- Back-pressure: valid instruction with yumi low 3 cycles -> outputs unchanged, fetch_ready_o=0 while word unconsumed; reset asserted mid-stall -> instr_v_o=0 next cycle.
